alu_resp_unit: RTL and testbench

Handshaked, pipelined responder for the 8-bit ALU operation set: add, subtract, XOR and left shift. An initiator presents operand/opcode requests on a valid/ready port. The block computes each result in a registered stage and returns results strictly in request order through a DEPTH-entry result FIFO on a second valid/ready port. It is the hardware-side consumer of the ALU stimulus stream and replaces direct combinational ALU access wherever the result consumer can stall.

---
 rtl/alu_resp_unit.sv | 134 +++++++++++++
 tb/tb_alu_resp_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_unit.sv
// Handshaked ALU responder: one registered compute stage feeding a show-ahead
// result FIFO, so results return in request order and the consumer can stall.
module alu_resp_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  input  logic [1:0]             req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_flag,
  output logic [1:0]             rsp_op,
  output logic [$clog2(DEPTH):0] rsp_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = WIDTH + 3;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpXor = 2'b10,
    OpShl = 2'b11
  } alu_op_e;

  logic             accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_flag;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic             s1_flag;
  logic [1:0]       s1_op;

  logic [EntryW-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count_next;
  logic              push;
  logic              pop;
  logic [EntryW-1:0] head;

  // Admission counts the S1 entry as already occupying a FIFO slot, which is
  // what makes overflow impossible without looking at rsp_ready.
  assign req_ready = !rst &&
                     (({1'b0, rsp_count} + (CntW + 1)'(s1_valid)) < (CntW + 1)'(DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    alu_result = '0;
    alu_flag   = 1'b0;
    case (alu_op_e'(req_op))
      OpAdd: {alu_flag, alu_result} = {1'b0, req_a} + {1'b0, req_b};
      OpSub: {alu_flag, alu_result} = {1'b0, req_a} - {1'b0, req_b};
      OpXor: alu_result = req_a ^ req_b;
      OpShl: begin
        alu_result = {req_a[WIDTH-2:0], 1'b0};
        alu_flag   = req_a[WIDTH-1];
      end
      default: begin
        alu_result = '0;
        alu_flag   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_flag   <= 1'b0;
      s1_op     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_result <= alu_result;
        s1_flag   <= alu_flag;
        s1_op     <= req_op;
      end
    end
  end

  assign push = s1_valid;
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    count_next = rsp_count;
    case ({push, pop})
      2'b10:   count_next = rsp_count + CntW'(1);
      2'b01:   count_next = rsp_count - CntW'(1);
      default: count_next = rsp_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      rsp_count <= count_next;
    end
  end

  // Storage needs no reset: an entry is only visible once rsp_count covers it.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {s1_flag, s1_op, s1_result};
    end
  end

  assign rsp_valid = (rsp_count != '0);
  assign head      = rsp_valid ? mem[rd_ptr] : '0;

  always_comb begin
    rsp_flag   = head[EntryW-1];
    rsp_op     = head[EntryW-2:EntryW-3];
    rsp_result = head[WIDTH-1:0];
  end

endmodule

// File: tb/tb_alu_resp_unit.sv
// Randomised scoreboard bench for alu_resp_unit: accepted requests push the
// expected result into a queue, the monitor pops and compares on every pop.
module tb_alu_resp_unit;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_flag;
  logic [1:0]   rsp_op;
  logic [2:0]   rsp_count;

  alu_resp_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flag  (rsp_flag),
    .rsp_op    (rsp_op),
    .rsp_count (rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       flag;
    logic [1:0] op;
  } rsp_t;

  rsp_t q[$];
  bit   m_s1;
  int   total;
  int   bad;
  int   pops;
  int   accepts;

  function automatic rsp_t ref_alu(int unsigned a, int unsigned b, int unsigned op);
    int unsigned r;
    bit          f;
    rsp_t        o;
    case (op)
      0: begin r = a + b;       f = (r >= 256); end
      1: begin r = a + 256 - b; f = (a < b);    end
      2: begin r = a ^ b;       f = 1'b0;       end
      default: begin r = a * 2; f = (a >= 128); end
    endcase
    o.res  = 8'(r % 256);
    o.flag = f;
    o.op   = 2'(op);
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare at the falling edge, then advance the model past the
  // coming rising edge.
  always @(negedge clk) begin : mon
    int   fcnt;
    bit   ev;
    bit   er;
    bit   acc;
    rsp_t exp_r;
    fcnt = q.size() - int'(m_s1);
    ev   = (fcnt != 0);
    er   = !rst && ((fcnt + int'(m_s1)) < D);
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("rsp_count", 32'(rsp_count), 32'(fcnt));
    if (!ev) begin
      check("idle_outputs", 32'({rsp_result, rsp_flag, rsp_op}), 32'd0);
    end else if (rsp_ready) begin
      exp_r = q[0];
      check("rsp_data", 32'({rsp_result, rsp_flag, rsp_op}), 32'(exp_r));
    end
    if (rst) begin
      q.delete();
      m_s1 = 1'b0;
    end else begin
      if (ev && rsp_ready) begin
        void'(q.pop_front());
        pops++;
      end
      acc = req_valid && er;
      if (acc) begin
        q.push_back(ref_alu(req_a, req_b, req_op));
        accepts++;
      end
      m_s1 = acc;
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input int tmo, output bit got);
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    got       = 1'b0;
    for (int i = 0; i < tmo && !got; i++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    bit got;
    int a0;
    int p0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    total     = 0;
    bad       = 0;
    pops      = 0;
    accepts   = 0;
    m_s1      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First request right after reset must be taken in the first cycle.
    issue(8'hF0, 8'h20, 2'b00, 1, got);
    check("first_accept", 32'(got), 32'd1);
    idle(4);

    // Back-to-back ops with the consumer always ready.
    issue(8'h05, 8'h07, 2'b01, 3, got);
    check("b2b_sub", 32'(got), 32'd1);
    issue(8'hA5, 8'h0F, 2'b10, 3, got);
    check("b2b_xor", 32'(got), 32'd1);
    issue(8'h81, 8'h3C, 2'b11, 3, got);
    check("b2b_shl", 32'(got), 32'd1);
    idle(5);

    // Backpressure: only DEPTH requests fit.
    rsp_ready = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 6; i++) issue(8'h01, 8'(i), 2'b00, 3, got);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_accepts", 32'(accepts - a0), 32'(D));
    check("bp_count", 32'(rsp_count), 32'(D));
    check("bp_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    idle(8);

    // Fill, then stream random traffic with push and pop every cycle.
    rsp_ready = 1'b0;
    for (int i = 0; i < int'(D); i++) issue(8'($urandom), 8'($urandom), 2'($urandom), 3, got);
    rsp_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), 2'($urandom), 10, got);
      check("stream_accept", 32'(got), 32'd1);
    end
    idle(10);
    check("stream_wrap", 32'(pops - p0 >= 3 * int'(D)), 32'd1);

    // Reset with three results queued and S1 occupied.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(8'($urandom), 8'($urandom), 2'($urandom), 3, got);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    issue(8'h00, 8'h00, 2'b00, 3, got);
    check("post_rst_accept", 32'(got), 32'd1);
    idle(5);

    // Invalid traffic must leave the block idle.
    a0 = accepts;
    for (int i = 0; i < 10; i++) begin
      req_a  = 8'($urandom);
      req_b  = 8'($urandom);
      req_op = 2'($urandom);
      @(posedge clk);
      #1;
    end
    check("invalid_accepts", 32'(accepts - a0), 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
